vector_lane_alu_pipe: RTL
=========================

# vector_lane_alu_pipe

Pipelined, packed-SIMD vector ALU for one lane. It processes one LONGEST_LEN-bit beat per cycle, holding LONGEST_LEN/SEW elements. It adds per-element mask-undisturbed writeback, multiply ops, unsigned min/max, and a multi-beat sum reduction. A valid/ready handshake sits on both sides. It sits between the lane's operand-read stage and the vector register writeback.

## Interface
- LONGEST_LEN, 64, beat width in bits; multiple of 64.
- PIPE_STAGES, 3, fixed beat latency; legal range 2..6.
- EW, LONGEST_LEN/8, derived (localparam); number of mask bits (max elements per beat).

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- vsew  in  3  element width, codebase `ONE_BYTE/`TWO_BYTE/`FOUR_BYTE/`EIGHT_BYTE
- op  in  4  0 ADD, 1 SUB, 2 MUL, 3 MACC, 4 NMSAC, 5 MINU, 6 MAXU, 7 REDSUM; others illegal
- vm  in  1  1 = unmasked
- mask  in  EW  per-element mask; bit i applies to element i of the current SEW
- vs1, vs2, vs3  in  LONGEST_LEN  packed operands; vs3 = old vd
- in_last  in  1  last beat of a REDSUM group; ignored for other ops
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  LONGEST_LEN  packed result
- err  out  1  one-cycle pulse at output time for a beat with illegal op/vsew or a protocol violation

## Operation
- Elements: n = LONGEST_LEN/SEW. Element i occupies bits [i*SEW +: SEW]. Element i is active iff vm || mask[i]. mask bits ≥ n are ignored.
- All arithmetic is modulo 2^SEW, with no carry across element boundaries.
- ADD: vs2+vs1. SUB: vs2−vs1. MUL: low SEW bits of vs2*vs1.
- MACC: vs1*vs2+vs3. NMSAC: vs3−vs1*vs2.
- MINU/MAXU: unsigned compare of vs2 and vs1.
- Inactive elements: result element = vs3 element (mask-undisturbed, not zeroed).
- REDSUM:
  - The group starts on the first accepted REDSUM beat while idle. The accumulator (SEW wide) is loaded with vs1 element 0 plus the sum of active vs2 elements.
  - Each following beat adds its active vs2 elements.
  - Non-last beats produce no output.
  - On the in_last beat: result element 0 = final accumulator, and bits above SEW = vs3 (tail-undisturbed). The accumulator then returns to idle.
  - A single beat with in_last=1 forms a complete group.
- Illegal op or vsew: result = vs3, and err pulses with that beat's out_valid.
- A non-REDSUM beat accepted mid-group aborts the group: the accumulator clears, that beat executes normally, and err pulses with it. The aborted group produces no output.
- vsew or op changes between beats are legal. Each beat uses its own captured fields.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, err=0, accumulator=0, reduction state=idle, all stage-valid bits 0.
- Reset mid-operation discards all in-flight beats and any partial reduction. No output follows reset.
- Latency: a beat accepted at cycle t drives out_valid at cycle t+PIPE_STAGES, provided no stall occurred. This holds for every op.
- Throughput: one beat per cycle.
- Stall: when out_valid && !out_ready, the whole pipeline freezes and in_ready=0 in the same cycle (combinational).
- result, err and out_valid must hold stable while stalled.
- in_ready = !(out_valid && !out_ready).
- Simultaneous output handshake and input accept advance the pipe by one slot. Nothing is dropped or duplicated.
- Reduction accumulation happens in the final stage. A back-to-back REDSUM beat sees the prior beat's sum with no bubble.
- Non-last REDSUM beats leave a bubble (out_valid=0) in their output slot.

## Test plan
- SEW=8, vm=1, ADD, vs1=0x0101_0101_0101_01FF, vs2=0x0000_0000_0000_0001 → result 0x0101_0101_0101_0100 (no carry into element 1), 3 cycles after accept.
- SEW=16, vm=0, mask=0b0101, MACC, vs1=vs2=0x0003 in every element, vs3=0x1111 in every element → result 0x1111_111A_1111_111A.
- SEW=32, REDSUM, 3 beats:
  - beat 1: vs1[0]=5, vs2={1,2}
  - beat 2: vs2={3,4}
  - beat 3: vs2={10,0}, in_last=1, vs3=0xAAAA_AAAA_0000_0000
  - → single output 0xAAAA_AAAA_0000_0019, and out_valid is low for beats 1 and 2.
- Stream 6 ADD beats with out_ready held low for cycles 4–7 → in_ready low exactly while stalled, all 6 results delivered in order, and result stable during the stall.
- op=0xF, vs3=0x1234 → result 0x1234 with err=1 for one output cycle. Also a REDSUM beat then an ADD beat → err on the ADD output, no reduction output.
- Assert rst for one cycle while 2 beats are in flight and a reduction is open → out_valid=0 for the next PIPE_STAGES cycles, and a fresh REDSUM starts from vs1[0].

Source files
------------

// File: rtl/vector_lane_alu_pipe.sv
// Packed-SIMD vector ALU for one lane: elementwise add/sub/mul/macc/nmsac/minu/maxu
// with mask-undisturbed writeback, plus a multi-beat REDSUM reduction that
// accumulates in the final stage. Fixed PIPE_STAGES latency, whole-pipe stall.
// vsew encoding: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b; 4..7 illegal.
module vector_lane_alu_pipe #(
    parameter  int unsigned LONGEST_LEN = 64,
    parameter  int unsigned PIPE_STAGES = 3,
    localparam int unsigned EW          = LONGEST_LEN / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             vsew,
    input  logic [3:0]             op,
    input  logic                   vm,
    input  logic [EW-1:0]          mask,
    input  logic [LONGEST_LEN-1:0] vs1,
    input  logic [LONGEST_LEN-1:0] vs2,
    input  logic [LONGEST_LEN-1:0] vs3,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LONGEST_LEN-1:0] result,
    output logic                   err
);

    typedef enum logic [2:0] {
        SEW_8  = 3'd0,
        SEW_16 = 3'd1,
        SEW_32 = 3'd2,
        SEW_64 = 3'd3
    } sew_e;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_MACC   = 4'd3,
        OP_NMSAC  = 4'd4,
        OP_MINU   = 4'd5,
        OP_MAXU   = 4'd6,
        OP_REDSUM = 4'd7
    } op_e;

    typedef enum logic {
        RED_IDLE,
        RED_ACCUM
    } red_e;

    // Everything the final stage needs about one beat; elementwise work is done
    // before stage 1, the reduction only needs the per-beat partial sum.
    typedef struct packed {
        logic                   illegal;
        logic                   redsum;
        logic                   last;
        logic [1:0]             sew;
        logic [63:0]            e0;
        logic [63:0]            psum;
        logic [LONGEST_LEN-1:0] res;
        logic [LONGEST_LEN-1:0] vs3;
    } payload_t;

    function automatic logic [63:0] trunc_sew(input logic [63:0] v, input logic [1:0] s);
        case (s)
            2'd0:    return {56'd0, v[7:0]};
            2'd1:    return {48'd0, v[15:0]};
            2'd2:    return {32'd0, v[31:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [LONGEST_LEN-1:0] merge_low(input logic [LONGEST_LEN-1:0] tail,
                                                         input logic [63:0] v,
                                                         input logic [1:0] s);
        logic [LONGEST_LEN-1:0] m;
        m = tail;
        case (s)
            2'd0:    m[7:0]  = v[7:0];
            2'd1:    m[15:0] = v[15:0];
            2'd2:    m[31:0] = v[31:0];
            default: m[63:0] = v;
        endcase
        return m;
    endfunction

    logic                   stall;
    logic [LONGEST_LEN-1:0] alu_res;
    logic [63:0]            alu_psum;
    logic [63:0]            alu_e0;
    payload_t               in_pay;
    payload_t               tail;
    logic                   tail_vld;
    logic [63:0]            red_sum;

    logic [PIPE_STAGES-1:1] vld_q, vld_d;
    payload_t               pay_q [1:PIPE_STAGES-1];
    payload_t               pay_d [1:PIPE_STAGES-1];
    logic                   out_valid_q, out_valid_d;
    logic [LONGEST_LEN-1:0] result_q, result_d;
    logic                   err_q, err_d;
    logic [63:0]            acc_q, acc_d;
    red_e                   red_q, red_d;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign tail      = pay_q[PIPE_STAGES-1];
    assign tail_vld  = vld_q[PIPE_STAGES-1];

    // One datapath per element width, each sized to its own element.
    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int unsigned W = 8 << g;
        localparam int unsigned N = LONGEST_LEN / W;
        logic [W-1:0]           a, b, c, r, psum;
        logic [LONGEST_LEN-1:0] res;

        // Elementwise op with mask-undisturbed writeback and active-element sum.
        always_comb begin
            a    = '0;
            b    = '0;
            c    = '0;
            r    = '0;
            psum = '0;
            res  = '0;
            for (int unsigned i = 0; i < N; i++) begin
                a = vs2[i*W +: W];
                b = vs1[i*W +: W];
                c = vs3[i*W +: W];
                case (op)
                    OP_ADD:   r = a + b;
                    OP_SUB:   r = a - b;
                    OP_MUL:   r = a * b;
                    OP_MACC:  r = a * b + c;
                    OP_NMSAC: r = c - a * b;
                    OP_MINU:  r = (a < b) ? a : b;
                    OP_MAXU:  r = (a > b) ? a : b;
                    default:  r = c;
                endcase
                if (vm || mask[i]) begin
                    res[i*W +: W] = r;
                    psum          = psum + a;
                end else begin
                    res[i*W +: W] = c;
                end
            end
        end
    end

    // Select the datapath for the offered element width and build the stage-1 payload.
    always_comb begin
        alu_res  = vs3;
        alu_psum = '0;
        alu_e0   = '0;
        case (vsew)
            SEW_8: begin
                alu_res  = g_sew[0].res;
                alu_psum = 64'(g_sew[0].psum);
                alu_e0   = 64'(vs1[7:0]);
            end
            SEW_16: begin
                alu_res  = g_sew[1].res;
                alu_psum = 64'(g_sew[1].psum);
                alu_e0   = 64'(vs1[15:0]);
            end
            SEW_32: begin
                alu_res  = g_sew[2].res;
                alu_psum = 64'(g_sew[2].psum);
                alu_e0   = 64'(vs1[31:0]);
            end
            SEW_64: begin
                alu_res  = g_sew[3].res;
                alu_psum = g_sew[3].psum;
                alu_e0   = vs1[63:0];
            end
            default: ;
        endcase
        in_pay.illegal = op[3] || vsew[2];
        in_pay.redsum  = (op == OP_REDSUM);
        in_pay.last    = in_last;
        in_pay.sew     = vsew[1:0];
        in_pay.e0      = alu_e0;
        in_pay.psum    = alu_psum;
        in_pay.res     = alu_res;
        in_pay.vs3     = vs3;
    end

    // Delay line: advances one slot per cycle unless the output is stalled.
    always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        if (!stall) begin
            vld_d[1] = in_valid;
            pay_d[1] = in_pay;
            for (int unsigned s = 2; s < PIPE_STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                pay_d[s] = pay_q[s-1];
            end
        end
    end

    // Final stage: reduction accumulate, group abort detection, output register.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        err_d       = err_q;
        acc_d       = acc_q;
        red_d       = red_q;
        red_sum     = trunc_sew(((red_q == RED_IDLE) ? tail.e0 : acc_q) + tail.psum, tail.sew);
        if (!stall) begin
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            if (tail_vld) begin
                if (tail.illegal || !tail.redsum) begin
                    out_valid_d = 1'b1;
                    result_d    = tail.res;
                    err_d       = tail.illegal || (red_q == RED_ACCUM);
                    acc_d       = '0;
                    red_d       = RED_IDLE;
                end else if (tail.last) begin
                    out_valid_d = 1'b1;
                    result_d    = merge_low(tail.vs3, red_sum, tail.sew);
                    acc_d       = '0;
                    red_d       = RED_IDLE;
                end else begin
                    acc_d = red_sum;
                    red_d = RED_ACCUM;
                end
            end
        end
    end

    // State registers; payload flops carry no reset, only their valid bits do.
    always_ff @(posedge clk) begin
        pay_q <= pay_d;
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            red_q       <= RED_IDLE;
        end else begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            red_q       <= red_d;
        end
    end

endmodule
